// File: rtl/ar_freeze_sequencer.sv
// ============================================================================
// ar_freeze_sequencer
//
// Purpose:
//   Sequences Action Replay freeze entry and exit. Three request sources
//   (reset-trap, freeze-button, breakpoint) are latched as pending flags and
//   served one at a time in priority order reset > freeze > break. Serving a
//   request raises the level-7 interrupt and waits for the CPU vector fetch
//   acknowledge. Once acknowledged, the block owns the ROM-overlay and
//   cartridge-active flags until the AR code writes the exit register.
//   An unacknowledged interrupt is retried after a hold-off gap, and the
//   request is abandoned (sticky error) once the retries are used up. After
//   exit a cooldown window keeps new requests from being issued immediately.
//
// Parameters:
//   ACK_TIMEOUT  cycles int7 stays high without ack before a retry
//   HOLDOFF      cycles int7 is forced low between retries
//   MAX_RETRY    retries before the request is abandoned
//   COOLDOWN     cycles after exit during which no new request is issued
//
// Ports:
//   i_clk          system clock
//   i_reset        asynchronous active-high reset
//   i_enable       cartridge present; low returns everything to idle
//   i_boot         bootloader running; requests are held back while high
//   i_req_freeze   freeze-button pulse (1 cycle)
//   i_req_reset    reset-trap pulse (1 cycle)
//   i_req_break    breakpoint pulse (1 cycle)
//   i_int7_ack     CPU interrupt-vector read (level)
//   i_exit_wr      CPU write to mode register word 0
//   i_ovl_clr_wr   CPU write to the overlay-clear register
//   o_int7         level-7 interrupt request
//   o_ovr          chip-RAM ROM overlay
//   o_active       cartridge frozen/active
//   o_status[1:0]  cause of last issued freeze: 00 freeze, 01 break, 11 reset
//   o_busy         sequencer not idle
//   o_err          sticky: a request was abandoned
//   o_drop_cnt[7:0] requests discarded while frozen (saturating)
// ============================================================================
module ar_freeze_sequencer #(
    parameter int ACK_TIMEOUT = 1024,
    parameter int HOLDOFF     = 16,
    parameter int MAX_RETRY   = 3,
    parameter int COOLDOWN    = 64
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_boot,
    input  logic       i_req_freeze,
    input  logic       i_req_reset,
    input  logic       i_req_break,
    input  logic       i_int7_ack,
    input  logic       i_exit_wr,
    input  logic       i_ovl_clr_wr,
    output logic       o_int7,
    output logic       o_ovr,
    output logic       o_active,
    output logic [1:0] o_status,
    output logic       o_busy,
    output logic       o_err,
    output logic [7:0] o_drop_cnt
);

    // ------------------------------------------------------------------------
    // Counter widths: each counter holds 0..param
    // ------------------------------------------------------------------------
    localparam int ACK_W   = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam int HOLD_W  = (HOLDOFF     < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam int RETRY_W = (MAX_RETRY   < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int COOL_W  = (COOLDOWN    < 1) ? 1 : $clog2(COOLDOWN + 1);

    localparam logic [ACK_W-1:0]   ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLDOFF - 1);
    localparam logic [COOL_W-1:0]  COOL_LAST = COOL_W'(COOLDOWN - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    // Request source indices (bit positions in the pending vector)
    localparam int N_SRC      = 3;
    localparam int SRC_BREAK  = 0;
    localparam int SRC_FREEZE = 1;
    localparam int SRC_RESET  = 2;

    localparam logic [1:0] STAT_FREEZE = 2'b00;
    localparam logic [1:0] STAT_BREAK  = 2'b01;
    localparam logic [1:0] STAT_RESET  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD,
        ST_FROZEN,
        ST_COOL
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [N_SRC-1:0]   r_pend;
    logic [ACK_W-1:0]   r_ack_tmr;
    logic [HOLD_W-1:0]  r_hold_tmr;
    logic [COOL_W-1:0]  r_cool_tmr;
    logic [RETRY_W-1:0] r_retry;
    logic               r_int7;
    logic               r_ovr;
    logic               r_active;
    logic [1:0]         r_status;
    logic               r_busy;
    logic               r_err;
    logic [7:0]         r_drop_cnt;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [N_SRC-1:0] w_pulse;
    logic [N_SRC-1:0] w_sel;
    logic [1:0]       w_sel_status;
    logic             w_launch;
    logic             w_frozen;
    logic [N_SRC-1:0] w_pend_clr;
    logic [N_SRC-1:0] w_pend_next;
    logic [9:0]       w_drop_sum;
    logic [7:0]       w_drop_next;

    assign w_pulse[SRC_BREAK]  = i_req_break;
    assign w_pulse[SRC_FREEZE] = i_req_freeze;
    assign w_pulse[SRC_RESET]  = i_req_reset;

    assign w_frozen = (r_state == ST_FROZEN);

    // Fixed-priority pick among pending flags: reset > freeze > break
    always_comb begin
        w_sel        = '0;
        w_sel_status = STAT_RESET;
        if (r_pend[SRC_RESET]) begin
            w_sel[SRC_RESET] = 1'b1;
            w_sel_status     = STAT_RESET;
        end else if (r_pend[SRC_FREEZE]) begin
            w_sel[SRC_FREEZE] = 1'b1;
            w_sel_status      = STAT_FREEZE;
        end else if (r_pend[SRC_BREAK]) begin
            w_sel[SRC_BREAK] = 1'b1;
            w_sel_status     = STAT_BREAK;
        end
    end

    // A request is issued only from IDLE and never while the bootloader runs
    assign w_launch   = (r_state == ST_IDLE) && (|r_pend) && !i_boot;
    assign w_pend_clr = w_launch ? w_sel : '0;

    // Per-source pending flag. Clearing the served flag wins over a
    // simultaneous re-pulse of the same source (the re-pulse is absorbed);
    // pulses that arrive while frozen are discarded and counted instead.
    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_pend
            assign w_pend_next[gi] = w_pend_clr[gi] ? 1'b0
                                   : (r_pend[gi] | (w_pulse[gi] & ~w_frozen));
        end
    endgenerate

    // Drop counter adds one per pulsing source and saturates at 255
    always_comb begin
        w_drop_sum = {2'b00, r_drop_cnt};
        for (int i = 0; i < N_SRC; i++) begin
            w_drop_sum = w_drop_sum + 10'(w_pulse[i]);
        end
        w_drop_next = (w_drop_sum > 10'd255) ? 8'hFF : w_drop_sum[7:0];
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_pend     <= '0;
            r_ack_tmr  <= '0;
            r_hold_tmr <= '0;
            r_cool_tmr <= '0;
            r_retry    <= '0;
            r_int7     <= 1'b0;
            r_ovr      <= 1'b0;
            r_active   <= 1'b0;
            r_status   <= STAT_RESET;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (!i_enable) begin
            // Cartridge absent: abort whatever is in flight. Cause, error
            // and drop accounting are kept for software to inspect later.
            r_state    <= ST_IDLE;
            r_pend     <= '0;
            r_ack_tmr  <= '0;
            r_hold_tmr <= '0;
            r_cool_tmr <= '0;
            r_retry    <= '0;
            r_int7     <= 1'b0;
            r_ovr      <= 1'b0;
            r_active   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            if (w_frozen) begin
                r_drop_cnt <= w_drop_next;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_state   <= ST_REQ;
                        r_int7    <= 1'b1;
                        r_busy    <= 1'b1;
                        r_status  <= w_sel_status;
                        r_retry   <= '0;
                        r_ack_tmr <= '0;
                    end
                end

                ST_REQ: begin
                    // Ack is checked first so it wins over a same-cycle timeout
                    if (i_int7_ack) begin
                        r_state  <= ST_FROZEN;
                        r_int7   <= 1'b0;
                        r_ovr    <= 1'b1;
                        r_active <= 1'b1;
                    end else if (r_ack_tmr == ACK_LAST) begin
                        r_int7    <= 1'b0;
                        r_ack_tmr <= '0;
                        if (r_retry < RETRY_MAX) begin
                            r_state    <= ST_HOLD;
                            r_retry    <= r_retry + RETRY_W'(1);
                            r_hold_tmr <= '0;
                        end else begin
                            // Out of retries: give up on this request
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end
                    end else begin
                        r_ack_tmr <= r_ack_tmr + ACK_W'(1);
                    end
                end

                ST_HOLD: begin
                    // int7 stays low here; a stray ack is ignored
                    if (r_hold_tmr == HOLD_LAST) begin
                        r_state   <= ST_REQ;
                        r_int7    <= 1'b1;
                        r_ack_tmr <= '0;
                    end else begin
                        r_hold_tmr <= r_hold_tmr + HOLD_W'(1);
                    end
                end

                ST_FROZEN: begin
                    // Exit forces the overlay off, so a simultaneous overlay
                    // clear is naturally covered by the same branch.
                    if (i_exit_wr) begin
                        r_state    <= ST_COOL;
                        r_ovr      <= 1'b0;
                        r_active   <= 1'b0;
                        r_cool_tmr <= '0;
                    end else if (i_ovl_clr_wr) begin
                        r_ovr <= 1'b0;
                    end
                end

                ST_COOL: begin
                    if (r_cool_tmr == COOL_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cool_tmr <= r_cool_tmr + COOL_W'(1);
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_int7   <= 1'b0;
                    r_ovr    <= 1'b0;
                    r_active <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_int7     = r_int7;
    assign o_ovr      = r_ovr;
    assign o_active   = r_active;
    assign o_status   = r_status;
    assign o_busy     = r_busy;
    assign o_err      = r_err;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_ar_freeze_sequencer.sv
// ============================================================================
// tb_ar_freeze_sequencer
//
// Directed bench for ar_freeze_sequencer with small timing parameters.
// Each step drives stimulus, pushes the expected output vector
// {int7, ovr, active, status, busy, err, drop_cnt} onto a scoreboard, lets
// one clock edge pass and then pops and compares against the DUT outputs
// one time unit after the edge.
// ============================================================================
module tb_ar_freeze_sequencer;

    localparam int ACK_TIMEOUT = 8;
    localparam int HOLDOFF     = 2;
    localparam int MAX_RETRY   = 3;
    localparam int COOLDOWN    = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       boot = 1'b0;
    logic       req_freeze = 1'b0;
    logic       req_reset = 1'b0;
    logic       req_break = 1'b0;
    logic       int7_ack = 1'b0;
    logic       exit_wr = 1'b0;
    logic       ovl_clr_wr = 1'b0;
    logic       int7;
    logic       ovr;
    logic       active;
    logic [1:0] status;
    logic       busy;
    logic       err;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    ar_freeze_sequencer #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .HOLDOFF     (HOLDOFF),
        .MAX_RETRY   (MAX_RETRY),
        .COOLDOWN    (COOLDOWN)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_enable     (enable),
        .i_boot       (boot),
        .i_req_freeze (req_freeze),
        .i_req_reset  (req_reset),
        .i_req_break  (req_break),
        .i_int7_ack   (int7_ack),
        .i_exit_wr    (exit_wr),
        .i_ovl_clr_wr (ovl_clr_wr),
        .o_int7       (int7),
        .o_ovr        (ovr),
        .o_active     (active),
        .o_status     (status),
        .o_busy       (busy),
        .o_err        (err),
        .o_drop_cnt   (drop_cnt)
    );

    typedef struct {
        string       tag;
        logic [14:0] vec;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [14:0] mk(input logic i7, input logic ov, input logic ac,
                                       input logic [1:0] st, input logic bz,
                                       input logic er, input logic [7:0] dc);
        return {i7, ov, ac, st, bz, er, dc};
    endfunction

    function automatic void push(input string tag, input logic [14:0] v);
        exp_t e;
        e.tag = tag;
        e.vec = v;
        sb.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_cmp();
        exp_t        e;
        logic [14:0] obs;
        obs = {int7, ovr, active, status, busy, err, drop_cnt};
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %b required an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.vec) else begin
                n_fail++;
                $error("FAIL %s: observed {int7,ovr,act,st,busy,err,drop}=%b required %b",
                       e.tag, obs, e.vec);
            end
            $display("t=%0t %s int7=%b ovr=%b act=%b st=%b busy=%b err=%b drop=%0d",
                     $time, e.tag, int7, ovr, active, status, busy, err, drop_cnt);
        end
    endtask

    // One clock edge with an expected result queued before it
    task automatic step(input string tag, input logic [14:0] v);
        push(tag, v);
        tick();
        pop_cmp();
    endtask

    // Immediate check without advancing the clock
    task automatic now(input string tag, input logic [14:0] v);
        push(tag, v);
        pop_cmp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e_drop;

        // ---------------- reset state ----------------
        tick();
        tick();
        now("reset_state", mk(0, 0, 0, 2'b11, 0, 0, 8'd0));
        reset = 1'b0;

        // ---------------- freeze with ack 5 cycles after int7 ----------------
        req_freeze = 1'b1;
        step("frz_pend", mk(0, 0, 0, 2'b11, 0, 0, 8'd0));
        req_freeze = 1'b0;
        step("frz_int7", mk(1, 0, 0, 2'b00, 1, 0, 8'd0));
        repeat (4) step("frz_wait", mk(1, 0, 0, 2'b00, 1, 0, 8'd0));
        int7_ack = 1'b1;
        step("frz_enter", mk(0, 1, 1, 2'b00, 1, 0, 8'd0));
        int7_ack = 1'b0;

        // overlay clear leaves active and state alone
        ovl_clr_wr = 1'b1;
        step("ovl_clr", mk(0, 0, 1, 2'b00, 1, 0, 8'd0));
        ovl_clr_wr = 1'b0;

        // three freeze pulses while frozen are dropped
        for (int i = 1; i <= 3; i++) begin
            req_freeze = 1'b1;
            step("drop", mk(0, 0, 1, 2'b00, 1, 0, 8'(i)));
            req_freeze = 1'b0;
        end

        exit_wr = 1'b1;
        step("exit", mk(0, 0, 0, 2'b00, 1, 0, 8'd3));
        exit_wr = 1'b0;
        repeat (COOLDOWN - 1) step("cool", mk(0, 0, 0, 2'b00, 1, 0, 8'd3));
        step("cool_done", mk(0, 0, 0, 2'b00, 0, 0, 8'd3));
        repeat (3) step("no_refreeze", mk(0, 0, 0, 2'b00, 0, 0, 8'd3));

        // ---------------- simultaneous break + reset ----------------
        req_break = 1'b1;
        req_reset = 1'b1;
        step("br_pend", mk(0, 0, 0, 2'b00, 0, 0, 8'd3));
        req_break = 1'b0;
        req_reset = 1'b0;
        step("rst_first", mk(1, 0, 0, 2'b11, 1, 0, 8'd3));
        int7_ack = 1'b1;
        step("rst_frozen", mk(0, 1, 1, 2'b11, 1, 0, 8'd3));
        int7_ack = 1'b0;
        exit_wr = 1'b1;
        step("rst_exit", mk(0, 0, 0, 2'b11, 1, 0, 8'd3));
        exit_wr = 1'b0;
        repeat (COOLDOWN - 1) step("cool", mk(0, 0, 0, 2'b11, 1, 0, 8'd3));
        step("cool_idle", mk(0, 0, 0, 2'b11, 0, 0, 8'd3));
        step("brk_second", mk(1, 0, 0, 2'b01, 1, 0, 8'd3));
        int7_ack = 1'b1;
        step("brk_frozen", mk(0, 1, 1, 2'b01, 1, 0, 8'd3));
        int7_ack = 1'b0;

        // exit and overlay clear together, then a pulse during cooldown
        exit_wr    = 1'b1;
        ovl_clr_wr = 1'b1;
        step("exit_both", mk(0, 0, 0, 2'b01, 1, 0, 8'd3));
        exit_wr    = 1'b0;
        ovl_clr_wr = 1'b0;
        req_freeze = 1'b1;
        step("cool_pulse", mk(0, 0, 0, 2'b01, 1, 0, 8'd3));
        req_freeze = 1'b0;
        repeat (COOLDOWN - 2) step("cool", mk(0, 0, 0, 2'b01, 1, 0, 8'd3));
        step("cool_idle2", mk(0, 0, 0, 2'b01, 0, 0, 8'd3));
        step("cool_latched", mk(1, 0, 0, 2'b00, 1, 0, 8'd3));

        // ---------------- no ack: retries then abandon ----------------
        for (int w = 0; w <= MAX_RETRY; w++) begin
            repeat (ACK_TIMEOUT - 1) step("win_hi", mk(1, 0, 0, 2'b00, 1, 0, 8'd3));
            if (w < MAX_RETRY) begin
                step("hold_lo", mk(0, 0, 0, 2'b00, 1, 0, 8'd3));
                if (w == 1) int7_ack = 1'b1;
                repeat (HOLDOFF - 1) step("hold_lo", mk(0, 0, 0, 2'b00, 1, 0, 8'd3));
                int7_ack = 1'b0;
                step("win_entry", mk(1, 0, 0, 2'b00, 1, 0, 8'd3));
            end else begin
                step("abandon", mk(0, 0, 0, 2'b00, 0, 1, 8'd3));
            end
        end
        repeat (2) step("idle_after", mk(0, 0, 0, 2'b00, 0, 1, 8'd3));

        // ---------------- ack in the timeout cycle wins ----------------
        req_freeze = 1'b1;
        step("tmo_pend", mk(0, 0, 0, 2'b00, 0, 1, 8'd3));
        req_freeze = 1'b0;
        step("tmo_entry", mk(1, 0, 0, 2'b00, 1, 1, 8'd3));
        repeat (ACK_TIMEOUT - 1) step("tmo_hi", mk(1, 0, 0, 2'b00, 1, 1, 8'd3));
        int7_ack = 1'b1;
        step("ack_at_timeout", mk(0, 1, 1, 2'b00, 1, 1, 8'd3));
        int7_ack = 1'b0;
        exit_wr = 1'b1;
        step("tmo_exit", mk(0, 0, 0, 2'b00, 1, 1, 8'd3));
        exit_wr = 1'b0;
        repeat (COOLDOWN - 1) step("cool", mk(0, 0, 0, 2'b00, 1, 1, 8'd3));
        step("cool_idle3", mk(0, 0, 0, 2'b00, 0, 1, 8'd3));

        // ---------------- enable dropped in REQ ----------------
        req_break = 1'b1;
        req_reset = 1'b1;
        step("en_pend", mk(0, 0, 0, 2'b00, 0, 1, 8'd3));
        req_break = 1'b0;
        req_reset = 1'b0;
        step("en_req", mk(1, 0, 0, 2'b11, 1, 1, 8'd3));
        enable = 1'b0;
        step("en_drop", mk(0, 0, 0, 2'b11, 0, 1, 8'd3));
        enable = 1'b1;
        repeat (3) step("en_cleared", mk(0, 0, 0, 2'b11, 0, 1, 8'd3));

        // ---------------- boot holds requests back ----------------
        boot = 1'b1;
        req_freeze = 1'b1;
        step("boot_pend", mk(0, 0, 0, 2'b11, 0, 1, 8'd3));
        req_freeze = 1'b0;
        repeat (3) step("boot_hold", mk(0, 0, 0, 2'b11, 0, 1, 8'd3));
        boot = 1'b0;
        step("boot_release", mk(1, 0, 0, 2'b00, 1, 1, 8'd3));
        int7_ack = 1'b1;
        step("boot_frozen", mk(0, 1, 1, 2'b00, 1, 1, 8'd3));
        int7_ack = 1'b0;

        // ---------------- drop counter saturation ----------------
        req_freeze = 1'b1;
        req_reset  = 1'b1;
        req_break  = 1'b1;
        repeat (83) tick();
        e_drop = 8'd255;
        step("drop_sat", mk(0, 1, 1, 2'b00, 1, 1, e_drop));
        step("drop_nowrap", mk(0, 1, 1, 2'b00, 1, 1, e_drop));
        req_freeze = 1'b0;
        req_reset  = 1'b0;
        req_break  = 1'b0;

        // ---------------- asynchronous reset while frozen ----------------
        #2;
        reset = 1'b1;
        #1;
        now("async_rst", mk(0, 0, 0, 2'b11, 0, 0, 8'd0));
        #1;
        reset = 1'b0;
        step("post_rst", mk(0, 0, 0, 2'b11, 0, 0, 8'd0));

        n_chk++;
        assert (sb.size() === 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d entries required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
